// File: rtl/adc_capture_wr_ctrl.sv
`timescale 1ns/1ps
// adc_capture_wr_ctrl
// Write side of the ADC capture memory. A capture fills the buffer with
// 2**ADDR_W samples at sequential addresses (ADC samples, or an internal ramp
// in self-test mode), then holds capture_done until the next capture starts.
// Re-capture via capture_again waits for the memory reader to release the
// buffer (rd_busy low).
//
// Optional build macro ADC_CAPTURE_PARITY_EN: widens mem_wdata by one bit
// carrying the even parity of the written sample.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | after reset, waiting for capture_start
// WRITE   | accepting samples and issuing memory writes
// DONE    | buffer full; waiting for capture_start or a released capture_again

module adc_capture_wr_ctrl #(
   parameter int DATA_W = 18,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture_start,
   input  logic              capture_again,
   input  logic              self_test_mode,
   input  logic              rd_busy,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_valid,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_waddr,
`ifdef ADC_CAPTURE_PARITY_EN
   output logic [DATA_W:0]   mem_wdata,
`else
   output logic [DATA_W-1:0] mem_wdata,
`endif
   output logic              capture_busy,
   output logic              capture_done,
   output logic [ADDR_W:0]   wr_count,
   output logic              again_lost
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] RAMP_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   state_t state;
   state_t state_nx;

   // Accepted-sample counter. Its low bits are the write pointer; the MSB
   // says every address has been claimed, so no further samples are taken
   // while the final write drains.
   logic [ADDR_W:0]   acc_cnt;
   logic [DATA_W-1:0] ramp;
   logic              again_pend;

   logic              restart;
   logic              accept;
   logic              last_wr;
   logic [DATA_W-1:0] sample;

   assign accept  = (state == ST_WRITE) && !acc_cnt[ADDR_W] &&
                    (self_test_mode || adc_valid);
   assign sample  = self_test_mode ? ramp : adc_data;
   assign last_wr = mem_wen && (mem_waddr == {ADDR_W{1'b1}});

   // Next-state decode; a restart from IDLE or DONE always lands in WRITE.
   always_comb begin
      state_nx = state;
      restart  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (capture_start) restart = 1'b1;
         end
         ST_WRITE: begin
            if (last_wr) state_nx = ST_DONE;
         end
         ST_DONE: begin
            if (capture_start || ((capture_again || again_pend) && !rd_busy))
               restart = 1'b1;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (restart) state_nx = ST_WRITE;
   end

   // State register with registered status flags derived from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         capture_busy <= 1'b0;
         capture_done <= 1'b0;
      end else begin
         state        <= state_nx;
         capture_busy <= (state_nx == ST_WRITE);
         capture_done <= (state_nx == ST_DONE);
      end
   end

   // Sample acceptance: pointer and ramp advance, write is issued next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_cnt   <= '0;
         ramp      <= '0;
         mem_wen   <= 1'b0;
         mem_waddr <= '0;
         mem_wdata <= '0;
      end else begin
         mem_wen <= accept;
         if (restart) begin
            acc_cnt <= '0;
            ramp    <= '0;
         end else if (accept) begin
            acc_cnt   <= acc_cnt + CNT_ONE;
            ramp      <= ramp + RAMP_ONE;
            mem_waddr <= acc_cnt[ADDR_W-1:0];
`ifdef ADC_CAPTURE_PARITY_EN
            mem_wdata <= {^sample, sample};
`else
            mem_wdata <= sample;
`endif
         end
      end
   end

   // Completed-write count, advanced once per issued write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count <= '0;
      end else if (restart) begin
         wr_count <= '0;
      end else if (mem_wen) begin
         wr_count <= wr_count + CNT_ONE;
      end
   end

   // Re-capture bookkeeping: pending request while the reader holds the
   // buffer, and a sticky flag for requests that arrived too early.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         again_pend <= 1'b0;
         again_lost <= 1'b0;
      end else if (restart) begin
         again_pend <= 1'b0;
         again_lost <= 1'b0;
      end else begin
         if (capture_again && (state == ST_DONE) && rd_busy) again_pend <= 1'b1;
         if (capture_again && (state != ST_DONE)) again_lost <= 1'b1;
      end
   end

endmodule

// File: doc/adc_capture_wr_ctrl.md
Name: adc_capture_wr_ctrl

Overview:
- Write side of the ADC capture memory: on a capture trigger, it stores incoming ADC samples at sequential addresses until the buffer is full, then flags done.
- Pairs with the packet controller's memory reader, which drains the buffer to the ADC_DATA pads.
- Re-arms on capture_again, but only once the reader has released the buffer.
- Sits in the digital top between the ADC sample interface and the capture SRAM write port.

Parameters:
DATA_W, 18, ADC sample width in bits
ADDR_W, 12, memory address width; buffer depth is 2**ADDR_W samples

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
capture_start  in  1  single-cycle pulse from regfile; starts a capture from IDLE or DONE
capture_again  in  1  single-cycle pulse from regfile; re-capture request, honoured only in DONE
self_test_mode  in  1  1 = write an internal ramp pattern instead of adc_data
rd_busy  in  1  memory reader active; blocks re-capture
adc_data  in  DATA_W  ADC sample
adc_valid  in  1  adc_data is valid this cycle
mem_wen  out  1  memory write enable
mem_waddr  out  ADDR_W  memory write address
mem_wdata  out  DATA_W (+1 with parity feature)  memory write data
capture_busy  out  1  high in WRITE state
capture_done  out  1  level; buffer full, held until next capture starts
wr_count  out  ADDR_W+1  samples written in the current or last capture
again_lost  out  1  sticky; capture_again arrived outside DONE; cleared by capture_start

Behaviour:
- Reset values: all outputs 0; state IDLE; address pointer 0; ramp 0; pending-again flag 0.
- States: IDLE, WRITE, DONE.
- IDLE, capture_start=1: go to WRITE; clear pointer, wr_count, ramp and again_lost.
- WRITE, sample source:
  - self_test_mode=0: a sample is accepted each cycle adc_valid=1.
  - self_test_mode=1: a sample is accepted every cycle and adc_valid is ignored.
- WRITE, write timing: on the cycle after acceptance, mem_wen=1, mem_waddr=pointer, and mem_wdata=sample (or ramp); then pointer and wr_count each increment by 1. Write latency is 1 cycle; all outputs are registered.
- WRITE, ramp: increments by 1 per accepted sample; DATA_W wide; wraps modulo 2**DATA_W.
- WRITE, full: on the cycle the write to address 2**ADDR_W-1 issues, go to DONE. capture_done rises the following cycle, with wr_count=2**ADDR_W. The pointer wraps to 0 but no further writes occur.
- capture_busy=1 exactly while in WRITE.
- DONE, capture_start=1: immediately restarts (as from IDLE) and clears capture_done.
- DONE, capture_again=1:
  - rd_busy=0: restart as capture_start.
  - rd_busy=1: set the pending flag; restart on the first cycle rd_busy=0.
- capture_again in IDLE or WRITE: ignored and sets again_lost.
- capture_start in WRITE: ignored; no pointer reset.
- capture_start and capture_again in the same cycle: treated as capture_start; the pending flag is cleared.
- rst asserted mid-capture: immediate return to reset values. A mem_wen in flight is dropped; no partial write completes after rst.

Optional Feature:
Macro ADC_CAPTURE_PARITY_EN.
- Defined: mem_wdata is DATA_W+1 bits; bit DATA_W is even parity over the written sample (XOR reduction), registered with the data, so latency is unchanged.
- Undefined: mem_wdata is DATA_W bits and no parity logic exists.

Test Plan:
- ADDR_W=4, self_test_mode=1, pulse capture_start at cycle 5 -> mem_wen high 16 consecutive cycles starting cycle 7; waddr 0..15, wdata 0..15; capture_done=1 at cycle 23; wr_count=16.
- self_test_mode=0, adc_valid on alternate cycles with adc_data=0x3A5A0+n -> 16 writes of 0x3A5A0..0x3A5AF, each 1 cycle after its valid; no write on invalid cycles.
- In DONE with rd_busy=1, pulse capture_again, then hold rd_busy high 10 cycles -> no restart; restart (capture_done=0, capture_busy=1) on the first cycle rd_busy=0.
- capture_again pulse in WRITE at write 8 -> capture continues to 16 writes; again_lost=1; next capture_start clears again_lost.
- Assert rst while in WRITE after 5 writes -> mem_wen=0 immediately; all outputs 0; a later capture_start writes from address 0.
- ADC_CAPTURE_PARITY_EN defined, adc_data=0x00007 -> mem_wdata[18]=1; adc_data=0x00003 -> mem_wdata[18]=0.
